// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: function codes, FSM state
// encodings and helpers that classify function codes.
package alu_pkg;

    // Function select codes
    localparam logic [3:0] AF_ADD  = 4'b0000;
    localparam logic [3:0] AF_ADDU = 4'b0001;
    localparam logic [3:0] AF_SUB  = 4'b0010;
    localparam logic [3:0] AF_SUBU = 4'b0011;
    localparam logic [3:0] AF_AND  = 4'b0100;
    localparam logic [3:0] AF_OR   = 4'b0101;
    localparam logic [3:0] AF_XOR  = 4'b0110;
    localparam logic [3:0] AF_LUI  = 4'b0111;
    localparam logic [3:0] AF_MUL  = 4'b1000;
    localparam logic [3:0] AF_SLT  = 4'b1010;
    localparam logic [3:0] AF_SLTU = 4'b1011;
    localparam logic [3:0] AF_DIVU = 4'b1100;
    localparam logic [3:0] AF_REMU = 4'b1101;

    // Controller states
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_MUL  = 2'b01;
    localparam logic [1:0] S_DIV  = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    // Divide and remainder share the iterative divider
    function automatic logic is_div(input logic [3:0] f);
        return (f == AF_DIVU) || (f == AF_REMU);
    endfunction

    // Everything except MUL/DIVU/REMU completes in the accept cycle;
    // undefined codes are single-cycle and yield zero
    function automatic logic is_single_cycle(input logic [3:0] f);
        return !((f == AF_MUL) || is_div(f));
    endfunction

endpackage

// File: rtl/imm_ext.sv
// Immediate extender: widens an IN_W immediate to OUT_W bits using either
// sign extension (u=0) or zero extension (u=1).
module imm_ext #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  in,
    input  logic             u,
    output logic [OUT_W-1:0] out
);

    generate
        if (OUT_W > IN_W) begin : g_ext
            logic fill;
            assign fill = u ? 1'b0 : in[IN_W-1];
            assign out  = {{(OUT_W - IN_W){fill}}, in};
        end else begin : g_pass
            assign out = in;
        end
    endgenerate

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU with valid/ready on both sides. Simple ops
// finish in one edge; unsigned MUL/DIVU/REMU iterate WIDTH times over a
// shared set of shift/accumulate registers.
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int IMM_W = 16,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [IMM_W-1:0] imm,
    input  logic [3:0]       af,
    input  logic             i_type,
    input  logic             u_ext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             dz
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    // acc: product accumulator / partial remainder
    // opa: multiplicand (shifts left) / quotient-dividend (shifts left)
    // opb: multiplier (shifts right) / divisor (constant)
    logic [WIDTH-1:0] acc, opa, opb;

    logic [WIDTH-1:0] imm_x, b_eff;
    logic             accept, div0, multi, last;
    logic [WIDTH-1:0] sum, diff, sc_res;
    logic             sc_ovf;
    logic [WIDTH-1:0] mul_acc_nxt, rem_nxt, quo_nxt;
    logic [WIDTH:0]   rem_sh, rem_sub;
    logic             div_ge;
    logic             res_load;
    logic [WIDTH-1:0] res_val;

    imm_ext #(.IN_W(IMM_W), .OUT_W(WIDTH)) u_imm_ext (
        .in  (imm),
        .u   (u_ext),
        .out (imm_x)
    );

    assign b_eff     = i_type ? imm_x : src_b;
    assign in_ready  = rst_n && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign div0      = is_div(af) && (b_eff == '0);
    assign multi     = !is_single_cycle(af) && !div0;
    assign last      = (cnt == LAST_ITER);

    // Single-cycle result and signed-overflow flag from the live inputs
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        sum    = src_a + b_eff;
        diff   = src_a - b_eff;
        sc_res = '0;
        sc_ovf = 1'b0;
        case (af)
            AF_ADD: begin
                sc_res = sum;
                sc_ovf = (src_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            AF_ADDU: sc_res = sum;
            AF_SUB: begin
                sc_res = diff;
                sc_ovf = (src_a[WIDTH-1] != b_eff[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            AF_SUBU: sc_res = diff;
            AF_AND:  sc_res = src_a & b_eff;
            AF_OR:   sc_res = src_a | b_eff;
            AF_XOR:  sc_res = src_a ^ b_eff;
            AF_LUI:  sc_res = {b_eff[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            AF_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(b_eff))};
            AF_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (src_a < b_eff)};
            default: sc_res = '0;
        endcase
    end

    // One shift-add multiply step and one restoring-divide step; the
    // remainder is shifted into WIDTH+1 bits so divisors with the MSB set
    // still compare correctly
    always_comb begin
        mul_acc_nxt = opb[0] ? (acc + opa) : acc;
        rem_sh      = {acc, opa[WIDTH-1]};
        rem_sub     = rem_sh - {1'b0, opb};
        div_ge      = !rem_sub[WIDTH];
        rem_nxt     = div_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nxt     = {opa[WIDTH-2:0], div_ge};
    end

    // Select the value that lands in the result register this edge
    always_comb begin
        res_load = 1'b0;
        res_val  = sc_res;
        if (accept && !multi) begin
            res_load = 1'b1;
            if (div0) begin
                res_val = (af == AF_DIVU) ? {WIDTH{1'b1}} : src_a;
            end
        end else if ((state == S_MUL) && last) begin
            res_load = 1'b1;
            res_val  = mul_acc_nxt;
        end else if ((state == S_DIV) && last) begin
            res_load = 1'b1;
            res_val  = (op_q == AF_REMU) ? rem_nxt : quo_nxt;
        end
    end

    // Controller and iterative datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            acc   <= '0;
            opa   <= '0;
            opb   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op_q <= af;
                        cnt  <= '0;
                        acc  <= '0;
                        opa  <= src_a;
                        opb  <= b_eff;
                        if (!multi)
                            state <= S_DONE;
                        else if (af == AF_MUL)
                            state <= S_MUL;
                        else
                            state <= S_DIV;
                    end else if ((state == S_DONE) && out_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    acc <= mul_acc_nxt;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt + CNT_W'(1);
                    if (last)
                        state <= S_DONE;
                end
                S_DIV: begin
                    acc <= rem_nxt;
                    opa <= quo_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (last)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result register with its zero/negative flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            zero   <= 1'b1;
            neg    <= 1'b0;
        end else if (res_load) begin
            result <= res_val;
            zero   <= (res_val == '0);
            neg    <= res_val[WIDTH-1];
        end
    end

    // Overflow / divide-by-zero flags, rewritten on every accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            dz  <= 1'b0;
        end else if (accept) begin
            ovf <= sc_ovf;
            dz  <= div0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32, IMM_W=16): directed cases,
// random back-to-back traffic, back-pressure and mid-divide reset.
module tb_seq_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  src_a = '0;
    logic [W-1:0]  src_b = '0;
    logic [15:0]   imm = '0;
    logic [3:0]    af = '0;
    logic          i_type = 1'b0;
    logic          u_ext = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          zero, neg, ovf, dz;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        dz;
    } exp_t;

    exp_t sb[$];

    seq_alu #(.WIDTH(W), .IMM_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_a     (src_a),
        .src_b     (src_b),
        .imm       (imm),
        .af        (af),
        .i_type    (i_type),
        .u_ext     (u_ext),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model using wide arithmetic
    function automatic exp_t model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      s;
        logic [63:0] p;
        e = '0;
        case (f)
            4'b0000: begin
                s = longint'($signed(a)) + longint'($signed(b));
                e.res = s[31:0];
                e.ovf = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
            end
            4'b0001: e.res = a + b;
            4'b0010: begin
                s = longint'($signed(a)) - longint'($signed(b));
                e.res = s[31:0];
                e.ovf = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
            end
            4'b0011: e.res = a - b;
            4'b0100: e.res = a & b;
            4'b0101: e.res = a | b;
            4'b0110: e.res = a ^ b;
            4'b0111: e.res = {b[15:0], 16'h0000};
            4'b1000: begin
                p = 64'(a) * 64'(b);
                e.res = p[31:0];
            end
            4'b1010: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1011: e.res = (a < b) ? 32'd1 : 32'd0;
            4'b1100: begin
                e.res = (b == 0) ? 32'hFFFFFFFF : a / b;
                e.dz  = (b == 0);
            end
            4'b1101: begin
                e.res = (b == 0) ? a : a % b;
                e.dz  = (b == 0);
            end
            default: e.res = '0;
        endcase
        return e;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drive one request (called just after a rising edge), wait for the
    // accepting edge and queue the expected result
    task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] im, input logic it, input logic ue, output int waits);
        logic [31:0] be;
        be = it ? (ue ? {16'h0000, im} : {{16{im[15]}}, im}) : b;
        af = f; src_a = a; src_b = b; imm = im; i_type = it; u_ext = ue;
        in_valid = 1'b1;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!in_ready && waits < 100);
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(model(f, a, be));
        #1 in_valid = 1'b0;
    endtask

    // Count edges from the accepting edge until out_valid is seen
    task automatic wait_out(input bit busy, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy && !out_valid) check("busy_in_ready", in_ready, 0);
        end while (!out_valid && lat < 100);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_result"}, result, 0);
        check({tag, "_zero"}, zero, 1);
        check({tag, "_neg"}, neg, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_dz"}, dz, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    // Scoreboard: compare each result as it is handed to the consumer
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("sb_result", result, e.res);
                    check("sb_zero", zero, (e.res == 0));
                    check("sb_neg", neg, e.res[31]);
                    check("sb_ovf", ovf, e.ovf);
                    check("sb_dz", dz, e.dz);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, lat;
        logic [3:0]  f;
        logic [31:0] a, b;

        #12;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Signed overflow on ADD
        issue(4'b0000, 32'h7FFFFFFF, 32'h1, 16'h0, 1'b0, 1'b0, w);
        wait_out(1'b0, lat);
        check("add_lat", lat, 1);
        check("add_res", result, 32'h80000000);
        check("add_ovf", ovf, 1);
        check("add_neg", neg, 1);
        step();

        // Immediate sign- and zero-extension
        issue(4'b0001, 32'h1, 32'h0, 16'hFFFF, 1'b1, 1'b0, w);
        wait_out(1'b0, lat);
        check("addi_s_res", result, 32'h0);
        check("addi_s_zero", zero, 1);
        step();
        issue(4'b0001, 32'h1, 32'h0, 16'hFFFF, 1'b1, 1'b1, w);
        wait_out(1'b0, lat);
        check("addi_u_res", result, 32'h00010000);
        step();

        // Iterative multiply
        issue(4'b1000, 32'h00010003, 32'h00000005, 16'h0, 1'b0, 1'b0, w);
        wait_out(1'b1, lat);
        check("mul_lat", lat, 33);
        check("mul_res", result, 32'h0005000F);
        step();

        // Divide / remainder, including divide by zero
        issue(4'b1100, 32'd100, 32'd7, 16'h0, 1'b0, 1'b0, w);
        wait_out(1'b1, lat);
        check("divu_lat", lat, 33);
        check("divu_res", result, 32'd14);
        step();
        issue(4'b1101, 32'd100, 32'd7, 16'h0, 1'b0, 1'b0, w);
        wait_out(1'b1, lat);
        check("remu_res", result, 32'd2);
        step();
        issue(4'b1100, 32'd5, 32'd0, 16'h0, 1'b0, 1'b0, w);
        wait_out(1'b0, lat);
        check("divz_lat", lat, 1);
        check("divz_res", result, 32'hFFFFFFFF);
        check("divz_dz", dz, 1);
        step();
        issue(4'b1101, 32'd5, 32'd0, 16'h0, 1'b0, 1'b0, w);
        wait_out(1'b0, lat);
        check("remz_res", result, 32'd5);
        check("remz_dz", dz, 1);
        step();

        // Random back-to-back traffic over every code
        for (int i = 0; i < 24; i++) begin
            f = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            issue(f, a, b, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
        end
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        check("drain_random", sb.size(), 0);
        step();

        // Back-pressure: result held while the consumer stalls
        out_ready = 1'b0;
        issue(4'b1010, 32'hFFFFFFFF, 32'h1, 16'h0, 1'b0, 1'b0, w);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_res", result, 1);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        step();
        out_ready = 1'b1;
        issue(4'b0110, 32'hA5A5A5A5, 32'h0F0F0F0F, 16'h0, 1'b0, 1'b0, w);
        check("b2b_same_cycle", w, 1);

        // Leave a nonzero result in place, then reset in the middle of a divide
        issue(4'b0010, 32'h80000000, 32'h1, 16'h0, 1'b0, 1'b0, w);
        wait_out(1'b0, lat);
        check("sub_ovf", ovf, 1);
        step();
        issue(4'b1100, 32'hF0000000, 32'd3, 16'h0, 1'b0, 1'b0, w);
        repeat (10) step();
        #2 rst_n = 1'b0;
        #1 check_reset("mid_div_reset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        issue(4'b0010, 32'd3, 32'd5, 16'h0, 1'b0, 1'b0, w);
        wait_out(1'b0, lat);
        check("post_rst_lat", lat, 1);
        check("post_rst_res", result, 32'hFFFFFFFE);
        check("post_rst_ovf", ovf, 0);
        step();

        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        check("drain_final", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
